// File: rtl/samm_operand_feeder.sv
// Operand feeder for the SAMM systolic array: loads A/B from the two-port RAM, then streams skewed wavefronts.
// Optional accumulator-clear strobe (acc_clr) is enabled by defining SAMM_FEED_ACC_CLR_EN.
module samm_operand_feeder #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   base_a,
    input  logic [AW-1:0]   base_b,
    output logic [AW-1:0]   ad1,
    output logic [AW-1:0]   ad2,
    input  logic [DW-1:0]   rd1,
    input  logic [DW-1:0]   rd2,
    output logic [N*DW-1:0] a_bus,
    output logic [N*DW-1:0] b_bus,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
`ifdef SAMM_FEED_ACC_CLR_EN
    output logic            acc_clr,
    output logic            done
`else
    output logic            done
`endif
);

    localparam int unsigned   NN     = N * N;
    localparam int unsigned   KW     = $clog2(NN);
    localparam int unsigned   TW     = $clog2(2 * N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(NN - 1);
    localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [TW-1:0]   t_q, t_d;
    logic [AW-1:0]   base_a_q, base_a_d;
    logic [AW-1:0]   base_b_q, base_b_d;
    logic [DW-1:0]   bank_a_q [NN];
    logic [DW-1:0]   bank_a_d [NN];
    logic [DW-1:0]   bank_b_q [NN];
    logic [DW-1:0]   bank_b_d [NN];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            t_q      <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            bank_a_q <= '{default: '0};
            bank_b_q <= '{default: '0};
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            t_q      <= t_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            bank_a_q <= bank_a_d;
            bank_b_q <= bank_b_d;
        end
    end

    // Next-state, bank capture and control outputs.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        t_d       = t_q;
        base_a_d  = base_a_q;
        base_b_d  = base_b_q;
        bank_a_d  = bank_a_q;
        bank_b_d  = bank_b_q;
        ad1       = '0;
        ad2       = '0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_a_d = base_a;
                    base_b_d = base_b;
                    k_d      = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ad1           = base_a_q + AW'(k_q);
                ad2           = base_b_q + AW'(k_q);
                bank_a_d[k_q] = rd1;
                bank_b_d[k_q] = rd2;
                if (k_q == K_LAST) begin
                    t_d     = '0;
                    state_d = ST_STREAM;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (t_q == T_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane i carries A[i][t-i] west and B[t-i][i] north; lanes outside the wavefront are zero.
    always_comb begin
        int unsigned tt;
        tt    = 32'(t_q);
        a_bus = '0;
        b_bus = '0;
        if (state_q == ST_STREAM) begin
            for (int unsigned i = 0; i < N; i++) begin
                if ((tt >= i) && ((tt - i) < N)) begin
                    a_bus[DW*i +: DW] = bank_a_q[KW'(i * N + (tt - i))];
                    b_bus[DW*i +: DW] = bank_b_q[KW'((tt - i) * N + i)];
                end
            end
        end
    end

`ifdef SAMM_FEED_ACC_CLR_EN
    assign acc_clr = (state_q == ST_LOAD) && (k_q == K_LAST);
`endif

endmodule

// File: tb/tb_samm_operand_feeder.sv
// Directed self-checking bench for samm_operand_feeder (N=4, AW=10, DW=8) with a behavioural RAM.
module tb_samm_operand_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_a, base_b;
    logic [9:0]  ad1, ad2;
    logic [7:0]  rd1, rd2;
    logic [31:0] a_bus, b_bus;
    logic        out_valid, out_ready, busy, done;
`ifdef SAMM_FEED_ACC_CLR_EN
    logic        acc_clr;
`endif

    logic [7:0] ram [1024];
    assign rd1 = ram[ad1];
    assign rd2 = ram[ad2];

    always #5 clk = ~clk;

    samm_operand_feeder #(.N(4), .AW(10), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_a    (base_a),
        .base_b    (base_b),
        .ad1       (ad1),
        .ad2       (ad2),
        .rd1       (rd1),
        .rd2       (rd2),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
`ifdef SAMM_FEED_ACC_CLR_EN
        .acc_clr   (acc_clr),
`endif
        .done      (done)
    );

    typedef struct {
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t tab [24];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;
    int   done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [9:0] ba, input logic [9:0] bb);
        start  = 1'b1;
        base_a = ba;
        base_b = bb;
        tick();
        start  = 1'b0;
    endtask

    task automatic check_load(input logic [9:0] ba, input logic [9:0] bb);
        for (int k = 0; k < 16; k++) begin
            check("load_ad1", 32'(ad1), 32'((ba + 10'(k)) & 10'h3FF));
            check("load_ad2", 32'(ad2), 32'((bb + 10'(k)) & 10'h3FF));
            check("load_busy", 32'(busy), 32'h1);
`ifdef SAMM_FEED_ACC_CLR_EN
            check("acc_clr", 32'(acc_clr), (k == 15) ? 32'h1 : 32'h0);
`endif
            tick();
        end
    endtask

    task automatic apply(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            out_ready = tab[i].rdy;
            check("beat_valid", 32'(out_valid), 32'(tab[i].exp_valid));
            check("beat_a", a_bus, tab[i].exp_a);
            check("beat_b", b_bus, tab[i].exp_b);
            check("beat_done", 32'(done), 32'h0);
            tick();
        end
        out_ready = 1'b1;
    endtask

    task automatic check_done();
        check("done_pulse", 32'(done), 32'h1);
        check("done_busy", 32'(busy), 32'h1);
        check("done_valid", 32'(out_valid), 32'h0);
        check("done_abus", a_bus, 32'h0);
        tick();
        check("idle_done", 32'(done), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 1024; a++) ram[a] = 8'(a + 1);

        // basic run beats (A = 1..16, B = 0x11..0x20)
        tab[0]  = '{1'b1, 1'b1, 32'h00000001, 32'h00000011};
        tab[1]  = '{1'b1, 1'b1, 32'h00000502, 32'h00001215};
        tab[2]  = '{1'b1, 1'b1, 32'h00090603, 32'h00131619};
        tab[3]  = '{1'b1, 1'b1, 32'h0D0A0704, 32'h14171A1D};
        tab[4]  = '{1'b1, 1'b1, 32'h0E0B0800, 32'h181B1E00};
        tab[5]  = '{1'b1, 1'b1, 32'h0F0C0000, 32'h1C1F0000};
        tab[6]  = '{1'b1, 1'b1, 32'h10000000, 32'h20000000};
        // backpressure: beat2 held for three stalled cycles
        tab[7]  = '{1'b1, 1'b1, 32'h00000001, 32'h00000011};
        tab[8]  = '{1'b1, 1'b1, 32'h00000502, 32'h00001215};
        tab[9]  = '{1'b0, 1'b1, 32'h00090603, 32'h00131619};
        tab[10] = '{1'b0, 1'b1, 32'h00090603, 32'h00131619};
        tab[11] = '{1'b0, 1'b1, 32'h00090603, 32'h00131619};
        tab[12] = '{1'b1, 1'b1, 32'h00090603, 32'h00131619};
        tab[13] = '{1'b1, 1'b1, 32'h0D0A0704, 32'h14171A1D};
        tab[14] = '{1'b1, 1'b1, 32'h0E0B0800, 32'h181B1E00};
        tab[15] = '{1'b1, 1'b1, 32'h0F0C0000, 32'h1C1F0000};
        tab[16] = '{1'b1, 1'b1, 32'h10000000, 32'h20000000};
        // address wrap: A = ram[1020..1023], ram[0..11] = FD FE FF 00 01 .. 0C
        tab[17] = '{1'b1, 1'b1, 32'h000000FD, 32'h00000011};
        tab[18] = '{1'b1, 1'b1, 32'h000001FE, 32'h00001215};
        tab[19] = '{1'b1, 1'b1, 32'h000502FF, 32'h00131619};
        tab[20] = '{1'b1, 1'b1, 32'h09060300, 32'h14171A1D};
        tab[21] = '{1'b1, 1'b1, 32'h0A070400, 32'h181B1E00};
        tab[22] = '{1'b1, 1'b1, 32'h0B080000, 32'h1C1F0000};
        tab[23] = '{1'b1, 1'b1, 32'h0C000000, 32'h20000000};

        rst = 1'b0; start = 1'b0; base_a = '0; base_b = '0; out_ready = 1'b1;
        #12;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_abus", a_bus, 32'h0);
        check("rst_bbus", b_bus, 32'h0);
        check("rst_ad1", 32'(ad1), 32'h0);
        check("rst_ad2", 32'(ad2), 32'h0);
        @(negedge clk) rst = 1'b1;
        tick();

        // basic run: done 24 cycles after the start edge
        do_start(10'd0, 10'd16);
        check_load(10'd0, 10'd16);
        apply(0, 6);
        check_done();
        check("done_count_basic", 32'(done_cnt), 32'd1);

        // backpressure
        do_start(10'd0, 10'd16);
        check_load(10'd0, 10'd16);
        apply(7, 16);
        check_done();
        check("done_count_bp", 32'(done_cnt), 32'd2);

        // address wrap
        do_start(10'd1020, 10'd16);
        check_load(10'd1020, 10'd16);
        apply(17, 23);
        check_done();

        // start while busy is ignored
        do_start(10'd0, 10'd16);
        for (int k = 0; k < 5; k++) tick();
        check("busy_ad1_k5", 32'(ad1), 32'd5);
        start = 1'b1; base_a = 10'd100;
        tick();
        start = 1'b0;
        for (int k = 6; k < 16; k++) begin
            check("busy_ad1", 32'(ad1), 32'(k));
            tick();
        end
        apply(0, 6);
        check_done();
        for (int k = 0; k < 5; k++) tick();
        check("done_count_busy", 32'(done_cnt), 32'd4);

        // reset at stream beat3 aborts without done
        do_start(10'd0, 10'd16);
        for (int k = 0; k < 16; k++) tick();
        apply(0, 2);
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        check("pre_rst_abus", a_bus, 32'h0D0A0704);
        rst = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_abus", a_bus, 32'h0);
        check("abort_bbus", b_bus, 32'h0);
        tick();
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        check("abort_no_done", 32'(done_cnt), 32'd4);
        check("abort_idle", 32'(busy), 32'h0);
        do_start(10'd0, 10'd16);
        check_load(10'd0, 10'd16);
        apply(0, 6);
        check_done();
        check("done_count_final", 32'(done_cnt), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/samm_operand_feeder.md
Name: samm_operand_feeder

Overview:
- Sits directly downstream of the two-port operand RAM in the SAMM datapath.
- Fetches an N x N matrix A on RAM port 1 and an N x N matrix B on RAM port 2, using the RAM's combinational read path, into internal register banks.
- Replays both banks as diagonally skewed operand wavefronts for the systolic array: A enters on the west edge, B on the north edge.
- Ready/valid handshake toward the array; start/busy/done toward the controller.

Parameters:
- N, 4, array dimension (rows = cols); legal 2..8.
- AW, 10, RAM address width.
- DW, 8, operand data width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request; sampled only in IDLE.
- base_a  input  AW  A start address (row-major), latched on accepted start.
- base_b  input  AW  B start address (row-major), latched on accepted start.
- ad1  output  AW  RAM port-1 address (A fetch).
- ad2  output  AW  RAM port-2 address (B fetch).
- rd1  input  DW  RAM port-1 read data, combinational from ad1.
- rd2  input  DW  RAM port-2 read data, combinational from ad2.
- a_bus  output  N*DW  west-edge lanes; lane i = bits [DW*i+DW-1 : DW*i].
- b_bus  output  N*DW  north-edge lanes; lane j = bits [DW*j+DW-1 : DW*j].
- out_valid  output  1  a_bus/b_bus hold a valid beat.
- out_ready  input  1  array accepts the beat.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at completion.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; k=0; t=0; both banks cleared to 0; latched bases=0.
- Reset output values: ad1=ad2=0, a_bus=b_bus=0, out_valid=0, busy=0, done=0.
- Reset asserted mid-LOAD or mid-STREAM aborts the operation with no done pulse.
- FSM states: IDLE -> LOAD -> STREAM -> DONE -> IDLE.
- IDLE: start=1 latches base_a/base_b, clears k, and moves to LOAD on the next edge.
- start is ignored in every state other than IDLE; no queueing.
- LOAD lasts exactly N*N cycles, k = 0..N*N-1.
  - ad1 = base_a + k and ad2 = base_b + k, truncated to AW bits (wrap modulo 2^AW; 1023+1 -> 0).
  - Each edge writes rd1 into bankA[k] and rd2 into bankB[k].
  - After k=N*N-1: go to STREAM with t=0.
  - bank index k = r*N + c is element [r][c].
- ad1/ad2 = 0 outside LOAD.
- STREAM: out_valid=1; beat counter t = 0..2N-2, i.e. 2N-1 beats.
  - a_bus lane i = A[i][t-i] if 0 <= t-i < N, else 0.
  - b_bus lane j = B[t-j][j] if 0 <= t-j < N, else 0.
  - Outputs are combinational from t and the banks.
  - t advances only on out_valid & out_ready. While out_ready=0, t and the buses hold stable.
  - Handshake on t=2N-2 moves to DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE. out_valid=0 and buses=0 outside STREAM.
- Latency: start to first beat = 1 + N*N cycles. Minimum start to done = N*N + 2N cycles.
- Banks retain their contents after completion until the next LOAD or reset.

Optional Feature:
- Macro: SAMM_FEED_ACC_CLR_EN.
- Defined:
  - Adds output port acc_clr (1 bit), reset 0.
  - acc_clr pulses high for exactly the last LOAD cycle (k=N*N-1), i.e. one cycle before the first beat, so the PE accumulators clear.
- Undefined: the port does not exist; all other behaviour is identical.

Test Plan:
- Basic run. Setup: N=4; RAM[0..15]=0x01..0x10; RAM[16..31]=0x11..0x20; base_a=0, base_b=16; out_ready=1; start.
  - LOAD: ad1 = 0..15 and ad2 = 16..31 over 16 cycles.
  - Beat0: a_bus=0x00000001, b_bus=0x00000011.
  - Beat1: a lanes{0,1}={0x02,0x05}, b lanes{0,1}={0x15,0x12}.
  - Beat6: a lane3=0x10, b lane3=0x20, other lanes 0.
  - done at cycle 24 after start.
- Backpressure: same setup, out_ready=0 for 3 cycles during beat2.
  - a_bus/b_bus/out_valid stable; beat3 appears only after out_ready returns to 1.
  - done is delayed by 3 cycles.
- Address wrap: base_a=1020.
  - ad1 sequence is 1020, 1021, 1022, 1023, 0, 1, ..., 11.
  - Bank contents match RAM at those addresses.
- Start while busy: pulse start with base_a=100 at LOAD k=5.
  - No effect; ad1 continues at base_a+6.
  - Exactly one done pulse.
- Reset mid-operation: assert rst low at STREAM beat3.
  - Immediately out_valid=0, busy=0, buses=0.
  - No done pulse.
  - A later start runs a fresh LOAD from k=0.
- Optional feature: with SAMM_FEED_ACC_CLR_EN defined, acc_clr=1 only in the cycle with ad1=base_a+15 (N=4).
